relu_serializer: RTL
====================

# relu_serializer

Downstream stage for the combinational linear layer. Captures one N-element signed result vector per valid/ready handshake, applies arithmetic right-shift requantization and ReLU to every element, and streams the N results out one element per cycle with an index and last flag. It feeds the next serial consumer, such as the next layer's input loader or an output port.

## Interface
- WIDTH, 16, bit-width of each input and output element.
- N, 4, vector length; must be ≥ 2.
- SHIFT, 0, arithmetic right-shift amount for requantization; valid range 0 to WIDTH-1.

- clk  in  1  the single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the upstream vector on `in` is valid.
- in_ready  out  1  the block accepts a vector this cycle.
- in  in  signed [WIDTH-1:0] [0:N-1]  result vector from the linear layer.
- out_valid  out  1  `out` holds a valid element.
- out_ready  in  1  the downstream consumer takes the element.
- out  out  signed [WIDTH-1:0]  requantized, ReLU'd element.
- out_idx  out  $clog2(N)  element index, 0 to N-1.
- out_last  out  1  high when out_idx == N-1.

## Operation
- **States** (`nn_pkg::ser_state_t`):
  - IDLE: holds no data.
  - SEND: holds a buffered vector.
- **Accept:** a vector is accepted when in_valid && in_ready. On acceptance:
  - buf[i] <= relu(in[i] >>> SHIFT) for all i.
  - idx <= 0.
  - state <= SEND.
- **relu(x):** returns x if x ≥ 0, otherwise 0. The shift is arithmetic, so the sign is preserved before the ReLU. The result always fits in WIDTH bits; there is no saturation logic.
- **in_ready:** `(state == IDLE) || (out_valid && out_ready && out_last)`, forced to 0 while rst is high. This allows back-to-back vectors with no bubble.
- **Output signals in SEND:**
  - out_valid = 1.
  - out = buf[idx].
  - out_idx = idx.
  - out_last = (idx == N-1).
- **Output signals in IDLE:** out_valid = 0, and out, out_idx and out_last are all 0.
- **Transfer:** a beat transfers when out_valid && out_ready.
  - If idx < N-1, idx increments.
  - If idx == N-1 and a new vector is accepted in the same cycle, the buffer reloads and idx returns to 0; the block stays in SEND.
  - If idx == N-1 and no new vector is accepted, state <= IDLE and idx <= 0.
- **Backpressure:** while out_valid && !out_ready, out, out_idx and out_last hold stable. Data never changes while valid is asserted and unacknowledged.
- **Reset:**
  - On reset, state = IDLE, idx = 0, buf = 0.
  - out_valid, out, out_idx and out_last are all 0; in_ready is 0 while rst is high.
  - Reset mid-stream discards the buffered vector. No further beats of that vector appear.
- **Input timing:** `in` is sampled only at acceptance. Changes on `in` at any other time have no effect.

## Timing
- **Latency:** a vector accepted at edge t produces element 0 on out in the cycle after edge t.
- **Throughput:** one element per cycle with out_ready held high. One vector every N cycles when back-to-back, with no idle cycle between vectors.
- **Combinational paths:**
  - out, out_valid, out_idx and out_last come directly from registers; there is no combinational path from in or in_valid.
  - in_ready has a combinational path from out_ready. The upstream stage must not make in_valid depend on in_ready.
- **First cycle after reset deassertion:** in_ready = 1 and out_valid = 0.

## Structure
- Package `nn_pkg` holds:
  - `ser_state_t` enum {IDLE, SEND}.
  - Function `relu_requant(x, shift)`, which is shared with other activation stages.
- Sub-module `relu_unit` (WIDTH, SHIFT) is a purely combinational per-element shift+ReLU. It is instantiated N times in a generate loop ahead of the buffer registers.
- The top level holds the FSM, the index counter, the buffer, and the output mux.

## Test plan
All scenarios use WIDTH=16 and N=4.
- **Basic, SHIFT=2:** in = {100, -8, 7, -1}, out_ready held 1 → beats 25, 0, 1, 0 on consecutive cycles, idx 0..3, out_last only on the 4th beat, then out_valid=0.
- **Extremes, SHIFT=2:** in = {16'h7FFF, 16'h8000, 3, -3} → 8191, 0, 0, 0.
- **Backpressure, SHIFT=0:** in = {1, 2, 3, 4}, with out_ready low for 3 cycles during beat 1 → out stays 2 with idx 1 throughout the stall; the full sequence is 1, 2, 3, 4 with no duplication; in_ready stays 0 until the last beat transfers.
- **Back-to-back, SHIFT=0:** vector A = {1, 2, 3, 4} then B = {5, 6, 7, 8}, with in_valid held high → A is accepted, in_ready pulses on A's last beat, and 8 beats 1..8 appear on 8 consecutive cycles.
- **Reset mid-stream:** rst is asserted after beat 1 of {9, 9, 9, 9} → next cycle out_valid=0, out=0, idx=0; after release, in_ready=1 and no remaining beats of the old vector ever appear.
- **Input hold:** `in` changes during SEND → output beats reflect only the value captured at acceptance.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network datapath stages.
package nn_pkg;

  // Serializer FSM states: IDLE holds nothing, SEND holds a buffered vector.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Widest element the shared activation helper supports.
  localparam int unsigned RELU_MAX_W = 64;

  // Arithmetic right-shift requantization followed by ReLU.
  // Callers sign-extend into RELU_MAX_W and truncate the result back to
  // their own width.
  function automatic logic signed [RELU_MAX_W-1:0] relu_requant(
    input logic signed [RELU_MAX_W-1:0] x,
    input int unsigned                  shift
  );
    logic signed [RELU_MAX_W-1:0] s;
    s = x >>> shift;
    return s[RELU_MAX_W-1] ? '0 : s;
  endfunction

endpackage

// File: rtl/relu_unit.sv
// Combinational per-element requantizing ReLU (arithmetic shift, then clamp at 0).
module relu_unit
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [WIDTH-1:0] i_x,
  output logic signed [WIDTH-1:0] o_y
);

  logic signed [RELU_MAX_W-1:0] w_ext;
  logic signed [RELU_MAX_W-1:0] w_res;

  // Sign-extend, apply the shared helper, and narrow back.
  // The result is never negative and never exceeds the input magnitude,
  // so truncation cannot lose information.
  assign w_ext = RELU_MAX_W'(i_x);
  assign w_res = relu_requant(w_ext, SHIFT);
  assign o_y   = WIDTH'(w_res);

endmodule

// File: rtl/relu_serializer.sv
// Captures one N-element vector per handshake, applies requant+ReLU, and
// streams the elements out one per cycle with an index and a last flag.
module relu_serializer
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned SHIFT = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [WIDTH-1:0]                in [0:N-1],
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [WIDTH-1:0]                out,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   out_idx,
  output logic                                   out_last
);

  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  ser_state_t                r_state;
  logic [IDXW-1:0]           r_idx;
  logic signed [WIDTH-1:0]   r_buf [0:N-1];
  logic                      r_out_valid;
  logic signed [WIDTH-1:0]   r_out;
  logic                      r_out_last;

  logic signed [WIDTH-1:0]   w_relu [0:N-1];
  logic                      w_out_fire;
  logic                      w_in_ready;
  logic                      w_accept;
  logic [IDXW-1:0]           w_idx_nxt;

  // One requantizing ReLU per element, ahead of the buffer registers.
  for (genvar g = 0; g < N; g++) begin : g_relu
    relu_unit #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT)
    ) u_relu (
      .i_x (in[g]),
      .o_y (w_relu[g])
    );
  end

  // Handshake decode; in_ready opens on the final beat so vectors chain without a bubble.
  assign w_out_fire = r_out_valid && out_ready;
  assign w_in_ready = !rst && ((r_state == IDLE) || (w_out_fire && r_out_last));
  assign w_accept   = in_valid && w_in_ready;
  assign w_idx_nxt  = r_idx + IDXW'(1);

  // FSM, index counter, buffer and registered output mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      // New vector: load buffer and present element 0 immediately.
      for (int i = 0; i < N; i++) r_buf[i] <= w_relu[i];
      r_state     <= SEND;
      r_idx       <= '0;
      r_out_valid <= 1'b1;
      r_out       <= w_relu[0];
      r_out_last  <= 1'b0;
    end else if (w_out_fire) begin
      if (r_out_last) begin
        r_state     <= IDLE;
        r_idx       <= '0;
        r_out_valid <= 1'b0;
        r_out       <= '0;
        r_out_last  <= 1'b0;
      end else begin
        r_idx       <= w_idx_nxt;
        r_out       <= r_buf[w_idx_nxt];
        r_out_last  <= (w_idx_nxt == IDXW'(N - 1));
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;

endmodule
